// File: rtl/polar_pkg.sv
// Shared constants and types for the SC decoder output path.
// Holds the frame size limits, counter widths and the packer state encoding.
package polar_pkg;

  localparam int PAIRS_MAX = 256;  // N/2 for N up to 512
  localparam int K_MAX     = 140;  // width of the packed info-bit register
  localparam int PCNT_W    = 9;    // holds 0..PAIRS_MAX
  localparam int KCNT_W    = 8;    // holds 0..K_MAX

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_OUT     = 2'd2
  } packer_state_e;

endpackage

// File: rtl/info_pair_sel.sv
// Frozen-bit filter for one decoded pair (u1, u2).
// Ports:
//   u1, u2             decoded bits, u1 first in decoding order
//   frozen_1, frozen_2 1 = corresponding bit is frozen and discarded
//   n_info             number of information bits in the pair (0..2)
//   bit_a              first info bit to append (valid when n_info >= 1)
//   bit_b              second info bit to append (valid when n_info == 2)
module info_pair_sel (
  input  logic       u1,
  input  logic       u2,
  input  logic       frozen_1,
  input  logic       frozen_2,
  output logic [1:0] n_info,
  output logic       bit_a,
  output logic       bit_b
);

  assign n_info = {1'b0, ~frozen_1} + {1'b0, ~frozen_2};
  // With u1 frozen, the only possible info bit is u2, so it moves to slot a.
  assign bit_a  = frozen_1 ? u2 : u1;
  // Slot b is only used when both bits are info bits.
  assign bit_b  = u2;

endmodule

// File: rtl/sc_info_bit_packer.sv
// Collects information bits from the SC decoder's size-2 leaf stage and
// presents one packed frame per programmed number of pairs.
// Ports:
//   clk, rst              clock (rising edge), synchronous active-high reset
//   start, frame_pairs    frame start pulse (IDLE only) and pair count
//   in_valid / in_ready   pair handshake; u1, u2, frozen_1, frozen_2 payload
//   out_valid / out_ready frame handshake
//   out_bits              info bits, bit 0 = first decoded info bit
//   out_k                 number of valid bits in out_bits
//   overflow              more than K_MAX info bits seen in the frame
module sc_info_bit_packer
  import polar_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [PCNT_W-1:0] frame_pairs,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              u1,
  input  logic              u2,
  input  logic              frozen_1,
  input  logic              frozen_2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [K_MAX-1:0]  out_bits,
  output logic [KCNT_W-1:0] out_k,
  output logic              overflow
);

  localparam logic [KCNT_W:0]   KLIM  = (KCNT_W+1)'(K_MAX);
  localparam logic [PCNT_W-1:0] PLIM  = PCNT_W'(PAIRS_MAX);

  packer_state_e     r_state;
  logic [PCNT_W-1:0] r_pairs;
  logic [PCNT_W-1:0] r_cnt;
  logic [KCNT_W-1:0] r_k;
  logic [K_MAX-1:0]  r_bits;
  logic              r_ovf;
  logic              r_in_ready;

  logic [1:0]        w_n_info;
  logic              w_bit_a;
  logic              w_bit_b;
  logic              w_acc;
  logic              w_wr_a;
  logic              w_wr_b;
  logic [KCNT_W:0]   w_idx_a;
  logic [KCNT_W:0]   w_idx_b;
  logic [KCNT_W:0]   w_k_sum;
  logic [KCNT_W-1:0] w_k_nxt;
  logic              w_ovf_hit;
  logic [K_MAX-1:0]  w_bits_nxt;
  logic [PCNT_W-1:0] w_fp_clamp;
  logic [PCNT_W-1:0] w_cnt_nxt;

  info_pair_sel u_sel (
    .u1       (u1),
    .u2       (u2),
    .frozen_1 (frozen_1),
    .frozen_2 (frozen_2),
    .n_info   (w_n_info),
    .bit_a    (w_bit_a),
    .bit_b    (w_bit_b)
  );

  assign w_acc      = in_valid && r_in_ready;
  assign w_wr_a     = (w_n_info != 2'd0);
  assign w_wr_b     = (w_n_info == 2'd2);
  // One extra bit so indices and the running count can exceed K_MAX
  // before being dropped / saturated.
  assign w_idx_a    = {1'b0, r_k};
  assign w_idx_b    = w_idx_a + (KCNT_W+1)'(1);
  assign w_k_sum    = w_idx_a + (KCNT_W+1)'(w_n_info);
  assign w_k_nxt    = (w_k_sum > KLIM) ? KCNT_W'(K_MAX) : w_k_sum[KCNT_W-1:0];
  assign w_ovf_hit  = (w_wr_a && (w_idx_a >= KLIM)) || (w_wr_b && (w_idx_b >= KLIM));
  assign w_fp_clamp = (frame_pairs > PLIM) ? PLIM : frame_pairs;
  assign w_cnt_nxt  = r_cnt + PCNT_W'(1);

  // Out-of-range indices never match a bit position, so dropped writes
  // fall out naturally.
  always_comb begin
    w_bits_nxt = r_bits;
    for (int i = 0; i < K_MAX; i++) begin
      if (w_wr_a && (w_idx_a == (KCNT_W+1)'(i))) w_bits_nxt[i] = w_bit_a;
      if (w_wr_b && (w_idx_b == (KCNT_W+1)'(i))) w_bits_nxt[i] = w_bit_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_pairs    <= '0;
      r_cnt      <= '0;
      r_k        <= '0;
      r_bits     <= '0;
      r_ovf      <= 1'b0;
      r_in_ready <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_pairs <= w_fp_clamp;
            r_cnt   <= '0;
            r_k     <= '0;
            r_bits  <= '0;
            r_ovf   <= 1'b0;
            if (w_fp_clamp != '0) begin
              r_state    <= ST_COLLECT;
              r_in_ready <= 1'b1;
            end else begin
              r_state    <= ST_OUT;
            end
          end
        end
        ST_COLLECT: begin
          if (w_acc) begin
            r_bits <= w_bits_nxt;
            r_k    <= w_k_nxt;
            r_ovf  <= r_ovf | w_ovf_hit;
            r_cnt  <= w_cnt_nxt;
            if (w_cnt_nxt == r_pairs) begin
              r_state    <= ST_OUT;
              r_in_ready <= 1'b0;
            end
          end
        end
        ST_OUT: begin
          if (out_ready) r_state <= ST_IDLE;
        end
        default: begin
          r_state    <= ST_IDLE;
          r_in_ready <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = (r_state == ST_OUT);
  assign out_bits  = r_bits;
  assign out_k     = r_k;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_sc_info_bit_packer.sv
module tb_sc_info_bit_packer;
  import polar_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [PCNT_W-1:0] frame_pairs;
  logic              in_valid;
  logic              in_ready;
  logic              u1, u2, frozen_1, frozen_2;
  logic              out_valid;
  logic              out_ready;
  logic [K_MAX-1:0]  out_bits;
  logic [KCNT_W-1:0] out_k;
  logic              overflow;

  sc_info_bit_packer dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .frame_pairs (frame_pairs),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .u1          (u1),
    .u2          (u2),
    .frozen_1    (frozen_1),
    .frozen_2    (frozen_2),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_bits    (out_bits),
    .out_k       (out_k),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [K_MAX-1:0] bits;
    int               k;
    bit               ovf;
  } exp_t;

  exp_t expq[$];
  int   errors = 0;
  int   checks = 0;
  bit   p_u1[512], p_u2[512], p_f1[512], p_f2[512];

  task automatic chk(input string name, input logic [K_MAX-1:0] act, input logic [K_MAX-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: list every non-frozen bit in decoding order, keep the first K_MAX.
  function automatic exp_t model(input int np);
    bit   q[$];
    exp_t e;
    e.bits = '0;
    for (int i = 0; i < np; i++) begin
      if (!p_f1[i]) q.push_back(p_u1[i]);
      if (!p_f2[i]) q.push_back(p_u2[i]);
    end
    for (int j = 0; j < q.size() && j < K_MAX; j++) e.bits[j] = q[j];
    e.k   = (q.size() > K_MAX) ? K_MAX : q.size();
    e.ovf = (q.size() > K_MAX);
    return e;
  endfunction

  // mode 0: random, 1: all info bits = 1, 2: all frozen with u = 1
  task automatic fill(input int np, input int mode);
    for (int i = 0; i < np; i++) begin
      case (mode)
        1:       begin p_u1[i] = 1; p_u2[i] = 1; p_f1[i] = 0; p_f2[i] = 0; end
        2:       begin p_u1[i] = 1; p_u2[i] = 1; p_f1[i] = 1; p_f2[i] = 1; end
        default: begin
          p_u1[i] = 1'($urandom); p_u2[i] = 1'($urandom);
          p_f1[i] = 1'($urandom); p_f2[i] = 1'($urandom);
        end
      endcase
    end
  endtask

  task automatic drive_pair(input int i);
    in_valid = 1; u1 = p_u1[i]; u2 = p_u2[i]; frozen_1 = p_f1[i]; frozen_2 = p_f2[i];
  endtask

  // Entered and left just after a rising edge. gap: 0 none, 1 idle between
  // pairs, 2 random idles. hold: extra cycles of out_ready low. inj: stray starts.
  task automatic send_frame(input int np, input logic [PCNT_W-1:0] fp, input int gap,
                            input int hold, input bit inj);
    int n;
    expq.push_back(model(np));
    start = 1; frame_pairs = fp;
    @(negedge clk);
    chk("idle out_valid", K_MAX'(out_valid), K_MAX'(0));
    chk("idle in_ready", K_MAX'(in_ready), K_MAX'(0));
    @(posedge clk); #1;
    start = 0; frame_pairs = PCNT_W'($urandom);
    if (np == 0) begin
      @(negedge clk);
      chk("zero frame out_valid", K_MAX'(out_valid), K_MAX'(1));
      chk("zero frame in_ready", K_MAX'(in_ready), K_MAX'(0));
    end else begin
      @(negedge clk);
      chk("start->in_ready", K_MAX'(in_ready), K_MAX'(1));
      @(posedge clk); #1;
      for (int i = 0; i < np; i++) begin
        if ((gap == 1 && i > 0) || (gap == 2 && $urandom_range(0, 2) == 0)) begin
          in_valid = 0; u1 = 1'($urandom); u2 = 1'($urandom);
          frozen_1 = 1'($urandom); frozen_2 = 1'($urandom);
          @(posedge clk); #1;
        end
        drive_pair(i);
        start = inj && ($urandom_range(0, 1) == 1);
        frame_pairs = PCNT_W'($urandom);
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 8) begin n++; @(negedge clk); end
        chk("in_ready before accept", K_MAX'(in_ready), K_MAX'(1));
        @(posedge clk); #1;
      end
      in_valid = 0; start = 0;
      @(negedge clk);
      chk("last accept->out_valid", K_MAX'(out_valid), K_MAX'(1));
      chk("in_ready after last", K_MAX'(in_ready), K_MAX'(0));
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      start = inj; frame_pairs = PCNT_W'($urandom);
    end
    @(posedge clk); #1;
    out_ready = 1; start = inj;
    @(posedge clk); #1;
    out_ready = 0; start = 0;
  endtask

  // Monitor: pops the scoreboard on each frame handshake and checks that a
  // back-pressured frame never changes.
  initial begin : monitor
    logic [K_MAX-1:0]  h_bits;
    logic [KCNT_W-1:0] h_k;
    logic              h_ovf;
    bit                held;
    exp_t              e;
    held = 0;
    forever begin
      @(negedge clk);
      if (rst || !out_valid) begin
        held = 0;
      end else begin
        if (held) begin
          chk("hold out_bits", out_bits, h_bits);
          chk("hold out_k", K_MAX'(out_k), K_MAX'(h_k));
          chk("hold overflow", K_MAX'(overflow), K_MAX'(h_ovf));
        end
        if (out_ready) begin
          held = 0;
          if (expq.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected frame: got out_k=%0d expected no frame", out_k);
          end else begin
            e = expq.pop_front();
            chk("out_bits", out_bits, e.bits);
            chk("out_k", K_MAX'(out_k), K_MAX'(e.k));
            chk("overflow", K_MAX'(overflow), K_MAX'(e.ovf));
          end
        end else begin
          held = 1; h_bits = out_bits; h_k = out_k; h_ovf = overflow;
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end

  initial begin : stim
    int np;
    rst = 1; start = 0; frame_pairs = '0; in_valid = 0; out_ready = 0;
    u1 = 0; u2 = 0; frozen_1 = 0; frozen_2 = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset in_ready", K_MAX'(in_ready), K_MAX'(0));
    chk("reset out_valid", K_MAX'(out_valid), K_MAX'(0));
    chk("reset out_bits", out_bits, K_MAX'(0));
    chk("reset out_k", K_MAX'(out_k), K_MAX'(0));
    chk("reset overflow", K_MAX'(overflow), K_MAX'(0));
    @(posedge clk); #1;
    rst = 0;

    // Reset mid-frame: nothing pushed to the scoreboard, so any frame is flagged.
    fill(4, 1);
    start = 1; frame_pairs = 4;
    @(posedge clk); #1;
    start = 0;
    for (int i = 0; i < 2; i++) begin drive_pair(i); @(posedge clk); #1; end
    in_valid = 0; rst = 1;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("rst mid in_ready", K_MAX'(in_ready), K_MAX'(0));
    chk("rst mid out_valid", K_MAX'(out_valid), K_MAX'(0));
    chk("rst mid out_k", K_MAX'(out_k), K_MAX'(0));
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst mid stays idle", K_MAX'(out_valid), K_MAX'(0));
    @(posedge clk); #1;

    // Mixed frozen pattern -> info bits 0,1,1,0
    p_u1[0] = 1; p_u2[0] = 0; p_f1[0] = 1; p_f2[0] = 0;
    p_u1[1] = 1; p_u2[1] = 1; p_f1[1] = 0; p_f2[1] = 0;
    p_u1[2] = 0; p_u2[2] = 1; p_f1[2] = 0; p_f2[2] = 1;
    send_frame(3, 3, 0, 0, 0);
    // All frozen, back to back with the previous frame
    fill(2, 2);
    send_frame(2, 2, 0, 0, 0);
    // Zero-length frame
    send_frame(0, 0, 0, 1, 0);
    // Toggling in_valid, out_ready low for 5 cycles after out_valid
    @(posedge clk); #1;
    fill(3, 0);
    send_frame(3, 3, 1, 4, 0);
    // Overflow, then a back-to-back all-frozen frame must come out cleared
    fill(71, 1);
    send_frame(71, 71, 0, 0, 0);
    fill(3, 2);
    send_frame(3, 3, 0, 0, 0);
    // Stray starts in COLLECT and OUT, followed by a back-to-back frame
    fill(5, 0);
    send_frame(5, 5, 2, 3, 1);
    fill(6, 0);
    send_frame(6, 6, 0, 0, 0);
    // frame_pairs above PAIRS_MAX clamps
    fill(PAIRS_MAX, 0);
    send_frame(PAIRS_MAX, PCNT_W'(300), 0, 0, 0);
    // Random frames
    for (int f = 0; f < 20; f++) begin
      if ($urandom_range(0, 1) == 1) begin @(posedge clk); #1; end
      np = $urandom_range(0, 80);
      fill(np, ($urandom_range(0, 4) == 0) ? 1 : 0);
      send_frame(np, PCNT_W'(np), 2, $urandom_range(0, 3), 1'($urandom));
    end

    repeat (4) @(posedge clk);
    chk("scoreboard drained", K_MAX'(expq.size()), K_MAX'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sc_info_bit_packer.md
Name: sc_info_bit_packer

Overview:
- Sits directly downstream of the SC decoder's size-2 leaf stage, which produces decoded pairs (u1, u2) together with their frozen flags.
- Each accepted pair is filtered: frozen bits are discarded, information bits are appended in decoding order to a packed frame register.
- When the programmed number of pairs for a frame has been consumed, the packed word and its information-bit count are presented on a valid/ready output handshake to the host output logic.

Parameters:
- PAIRS_MAX, 256, maximum pairs per frame (N/2, N up to 512)
- K_MAX, 140, width of the packed information-bit register
- PCNT_W, 9, width of the pair count/counter (holds 0..PAIRS_MAX)
- KCNT_W, 8, width of the info-bit count (holds 0..K_MAX)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  frame start pulse; honoured only in IDLE
- frame_pairs  in  PCNT_W  pairs in this frame; sampled together with start
- in_valid  in  1  leaf-stage pair valid
- in_ready  out  1  packer accepts a pair this cycle
- u1  in  1  first decoded bit of the pair
- u2  in  1  second decoded bit of the pair
- frozen_1  in  1  1 = u1 is frozen, discard it
- frozen_2  in  1  1 = u2 is frozen, discard it
- out_valid  out  1  packed frame available
- out_ready  in  1  consumer accepts the frame
- out_bits  out  K_MAX  info bits; bit 0 = first decoded info bit; unused MSBs = 0
- out_k  out  KCNT_W  number of valid info bits in out_bits
- overflow  out  1  more than K_MAX info bits seen in the frame; valid with out_valid

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- State machine: IDLE, COLLECT, OUT.
- Reset: state = IDLE; in_ready = 0; out_valid = 0; out_bits = 0; out_k = 0; overflow = 0; pair counter = 0.
- rst has priority over every other event. Asserting it mid-frame abandons the frame with no output.

IDLE:
- in_ready = 0, out_valid = 0.
- start = 1: latch frame_pairs; clear out_bits, out_k, overflow and the pair counter.
  - frame_pairs != 0: go to COLLECT.
  - frame_pairs == 0: go directly to OUT with out_k = 0.
- frame_pairs > PAIRS_MAX is clamped to PAIRS_MAX.

COLLECT:
- in_ready = 1 (registered; high the cycle after entry). A pair is accepted on in_valid && in_ready.
- Per accepted pair:
  - If u1 is not frozen, it is written at index k.
  - If u2 is not frozen, it is written at index k + (u1 not frozen).
  - k advances by 0, 1 or 2 accordingly.
- Order is always u1 before u2.
- Any write with index >= K_MAX is dropped and sets sticky overflow. k saturates at K_MAX.
- The pair counter increments on each accept.
- The accept that makes count == latched frame_pairs moves to OUT next cycle; in_ready drops in that same cycle.
- A frozen bit value is ignored regardless of its level (no check is made that it is 0).
- start is ignored in COLLECT and OUT.

OUT:
- out_valid = 1; out_bits, out_k and overflow are held stable while out_valid && !out_ready.
- out_valid && out_ready: go to IDLE next cycle; out_valid = 0.
- out_bits keeps its last value until the next start.

Latency and throughput:
- Last accepted pair to out_valid: 1 cycle.
- Pair throughput: 1 per cycle in COLLECT.
- start to in_ready high: 1 cycle.
- Back-to-back frames: start may be asserted in the cycle after the out handshake (IDLE).

Arithmetic and width:
- k is unsigned KCNT_W. The next-k computation uses KCNT_W+1 bits to detect overflow before saturation.

Decomposition:
- Shared package (polar_pkg):
  - K_MAX, PAIRS_MAX, PCNT_W, KCNT_W
  - packer state enum (IDLE, COLLECT, OUT)
- Sub-module info_pair_sel (combinational):
  - Inputs: u1, u2, frozen_1, frozen_2.
  - Outputs: n_info (0..2), bit_a, bit_b, giving the bits to append in order.
  - Reused by any later partial-sum stage that needs the same filtering.

Test Plan:
- Reset mid-COLLECT:
  - Stimulus: start with frame_pairs = 4, accept 2 pairs, assert rst for 1 cycle.
  - Required: state IDLE, in_ready = 0, out_valid = 0, out_k = 0, no output frame; a following start restarts cleanly.
- Mixed frozen pattern:
  - Stimulus: frame_pairs = 3; pairs (u1,u2,f1,f2) = (1,0,1,0), (1,1,0,0), (0,1,0,1).
  - Required: out_valid 1 cycle after the 3rd accept; out_k = 4; out_bits[3:0] = 4'b0110, i.e. bits 0..3 = 0,1,1,0; overflow = 0.
- All frozen, plus zero-length frame:
  - Stimulus: frame_pairs = 2 with f1 = f2 = 1 and u = 1.
  - Required: out_k = 0, out_bits = 0.
  - Stimulus: start with frame_pairs = 0.
  - Required: out_valid the next cycle, out_k = 0.
- Backpressure:
  - Stimulus: in_valid toggling 1,0,1; out_ready held 0 for 5 cycles after out_valid.
  - Required: only valid-high cycles count; out_* stable for all 5 cycles; IDLE 1 cycle after out_ready.
- Overflow:
  - Stimulus: frame_pairs = 71, all unfrozen, u1 = u2 = 1.
  - Required: out_k = 140; out_bits all ones; overflow = 1.
- Ignored start and back-to-back frames:
  - Stimulus: start pulses during COLLECT and during OUT.
  - Required: no effect on either frame.
  - Stimulus: second start the cycle after the handshake.
  - Required: the new frame is accepted with the register cleared.
